// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier returning the full 2*XLEN product.
// Optional MUL_EARLY_EXIT_EN ends RUN once every remaining multiplier digit is zero.
module booth_mul_iter #(
    parameter int XLEN            = 64,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int PW     = 2 * XLEN;
    localparam int BW     = XLEN + 3;
    localparam int D_FULL = XLEN / 2 + 1;
    localparam int N_FULL = (D_FULL + STEPS_PER_CYCLE - 1) / STEPS_PER_CYCLE;
    localparam int N_W    = (17 + STEPS_PER_CYCLE - 1) / STEPS_PER_CYCLE;
    localparam int CW     = $clog2(N_FULL + 1);
    localparam bit HAS_W  = XLEN > 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   n_lim;
    logic            mulw_q;
    logic [PW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [PW-1:0]   acc_q;
    logic [XLEN-1:0] res_hi_q;
    logic [XLEN-1:0] res_lo_q;

    logic [XLEN-1:0] a_red;
    logic [XLEN-1:0] b_red;
    logic [PW-1:0]   a_ext;
    logic [BW-1:0]   b_ext;
    logic [XLEN-1:0] fin_hi;
    logic [XLEN-1:0] fin_lo;

    logic [PW-1:0]   a_n;
    logic [BW-1:0]   b_n;
    logic [PW-1:0]   acc_n;
    logic [PW-1:0]   sel;
    logic            neg;
    logic            early;
    logic            fin;

    // Word ops squeeze operands to 32 bits first, then re-extend per signedness.
    generate
        if (HAS_W) begin : g_word
            assign a_red = mulw
                ? {{(XLEN-32){mul_signed[1] & multiplicand[31]}}, multiplicand[31:0]}
                : multiplicand;
            assign b_red = mulw
                ? {{(XLEN-32){mul_signed[0] & multiplier[31]}}, multiplier[31:0]}
                : multiplier;
            assign fin_lo = mulw_q
                ? {{(XLEN-32){acc_q[31]}}, acc_q[31:0]}
                : acc_q[XLEN-1:0];
            assign fin_hi = mulw_q
                ? {{(XLEN-32){acc_q[63]}}, acc_q[63:32]}
                : acc_q[PW-1:XLEN];
        end else begin : g_noword
            assign a_red  = multiplicand;
            assign b_red  = multiplier;
            assign fin_lo = acc_q[XLEN-1:0];
            assign fin_hi = acc_q[PW-1:XLEN];
        end
    endgenerate

    assign a_ext = {{XLEN{mul_signed[1] & a_red[XLEN-1]}}, a_red};
    assign b_ext = {{2{mul_signed[0] & b_red[XLEN-1]}}, b_red, 1'b0};

    assign n_lim = mulw_q ? CW'(N_W) : CW'(N_FULL);

`ifdef MUL_EARLY_EXIT_EN
    assign early = (cnt_q != '0) && ((b_q == '0) || (b_q == '1));
`else
    assign early = 1'b0;
`endif

    assign fin = (cnt_q == n_lim) || early;

    always_comb begin
        a_n   = a_q;
        b_n   = b_q;
        acc_n = acc_q;
        sel   = '0;
        neg   = 1'b0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            sel = '0;
            neg = 1'b0;
            unique case (b_n[2:0])
                3'b001, 3'b010: sel = a_n;
                3'b011:         sel = a_n << 1;
                3'b100: begin
                    sel = a_n << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    sel = a_n;
                    neg = 1'b1;
                end
                default:        sel = '0;
            endcase
            acc_n = acc_n + (neg ? ~sel : sel) + PW'(neg);
            a_n   = a_n << 2;
            b_n   = {{2{b_n[BW-1]}}, b_n[BW-1:2]};
        end
    end

    // The extra finalize cycle keeps the word-result mux off the adder path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mulw_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mul_valid && !flush) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        mulw_q  <= HAS_W && mulw;
                        a_q     <= a_ext;
                        b_q     <= b_ext;
                        acc_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (fin) begin
                        state_q  <= S_DONE;
                        res_hi_q <= fin_hi;
                        res_lo_q <= fin_lo;
                    end else begin
                        a_q   <= a_n;
                        b_q   <= b_n;
                        acc_q <= acc_n;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mul_ready = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// tb_booth_mul_iter: directed checks of booth_mul_iter at STEPS_PER_CYCLE 1, 2 and 4.
// Instance g uses STEPS_PER_CYCLE = 1 << g; all share operands, flush, out_ready, rst.
module tb_booth_mul_iter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        out_ready;
    logic        mv [3];
    logic        mr [3];
    logic        ov [3];
    logic [63:0] rh [3];
    logic [63:0] rl [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        booth_mul_iter #(
            .XLEN(64),
            .STEPS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .mul_valid(mv[g]),
            .mul_ready(mr[g]),
            .flush(flush),
            .mulw(mulw),
            .mul_signed(mul_signed),
            .multiplicand(multiplicand),
            .multiplier(multiplier),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .result_hi(rh[g]),
            .result_lo(rl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [1:0] s, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eh, input logic [63:0] el,
                          input int elat, input string nm);
        int lat;
        mul_signed   = s;
        mulw         = w;
        multiplicand = a;
        multiplier   = b;
        out_ready    = 1'b1;
        mv[idx]      = 1'b1;
        tick();
        mv[idx]      = 1'b0;
        multiplicand = {$urandom(), $urandom()};
        multiplier   = {$urandom(), $urandom()};
        mul_signed   = 2'($urandom());
        mulw         = 1'($urandom());
        lat = 0;
        while (ov[idx] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (elat >= 0) begin
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", nm, lat, elat);
            end
        end
        checks++;
        if (rh[idx] !== eh) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", nm, rh[idx], eh);
        end
        checks++;
        if (rl[idx] !== el) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", nm, rl[idx], el);
        end
        tick();
        checks++;
        if (mr[idx] !== 1'b1 || ov[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got ready=%b valid=%b want 1 0", nm, mr[idx], ov[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mr[i] !== 1'b1 || ov[i] !== 1'b0 || rh[i] !== 64'd0 || rl[i] !== 64'd0) begin
                errors++;
                $display("FAIL reset%0d: got ready=%b valid=%b hi=%h lo=%h want 1 0 0 0",
                         i, mr[i], ov[i], rh[i], rl[i]);
            end
        end
    endtask

    task automatic test_signed_modes();
        run_op(0, 2'b11, 1'b0, '1, '1, 64'd0, 64'd1, 34, "ss_m1xm1");
        run_op(0, 2'b00, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34, "uu_max");
        run_op(0, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, '1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 34, "su_m2");
        run_op(0, 2'b01, 1'b0, 64'd2, '1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34, "us_2xm1");
    endtask

    task automatic test_mulw();
        run_op(0, 2'b11, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 18, "w_ss");
        run_op(0, 2'b00, 1'b1, 64'hAAAA_5555_FFFF_FFFF, 64'h0F0F_0F0F_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 18, "w_uu");
    endtask

    task automatic test_hold_and_flush();
        int n;
        mul_signed   = 2'b00;
        mulw         = 1'b0;
        multiplicand = 64'd3;
        multiplier   = 64'd5;
        out_ready    = 1'b0;
        mv[0]        = 1'b1;
        tick();
        mv[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov[0] !== 1'b1 || mr[0] !== 1'b0 || rh[0] !== 64'd0 || rl[0] !== 64'd15) begin
                errors++;
                $display("FAIL hold%0d: got valid=%b ready=%b hi=%h lo=%h want 1 0 0 f",
                         i, ov[0], mr[0], rh[0], rl[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (mr[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got ready=%b valid=%b want 1 0", mr[0], ov[0]);
        end
        multiplicand = 64'd7;
        multiplier   = 64'd9;
        mv[0]        = 1'b1;
        tick();
        mv[0] = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (mr[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL run_flush: got ready=%b valid=%b want 1 0", mr[0], ov[0]);
        end
        n = 0;
        repeat (40) begin
            tick();
            if (ov[0] === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL flush_no_result: got %0d valid cycles want 0", n);
        end
        run_op(0, 2'b00, 1'b0, 64'd3, 64'd5, 64'd0, 64'd15, 34, "after_flush");
    endtask

    task automatic test_flush_corners();
        int n;
        mul_signed   = 2'b00;
        mulw         = 1'b0;
        multiplicand = 64'd3;
        multiplier   = 64'd5;
        mv[0]        = 1'b1;
        flush        = 1'b1;
        tick();
        mv[0] = 1'b0;
        flush = 1'b0;
        checks++;
        if (mr[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_flush_wins: got ready=%b want 1", mr[0]);
        end
        out_ready = 1'b0;
        mv[0]     = 1'b1;
        tick();
        mv[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || mr[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_flush: got valid=%b ready=%b want 0 1", ov[0], mr[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        mul_signed   = 2'b11;
        mulw         = 1'b0;
        multiplicand = 64'd11;
        multiplier   = 64'd13;
        mv[0]        = 1'b1;
        tick();
        mv[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (mr[0] !== 1'b1 || ov[0] !== 1'b0 || rh[0] !== 64'd0 || rl[0] !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b valid=%b hi=%h lo=%h want 1 0 0 0",
                     mr[0], ov[0], rh[0], rl[0]);
        end
        run_op(0, 2'b00, 1'b0, 64'd3, 64'd5, 64'd0, 64'd15, 34, "after_reset");
    endtask

    task automatic test_steps();
        run_op(1, 2'b11, 1'b0, '1, '1, 64'd0, 64'd1, 18, "s2_m1xm1");
        run_op(2, 2'b11, 1'b0, '1, '1, 64'd0, 64'd1, 10, "s4_m1xm1");
        run_op(1, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, '1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 18, "s2_su");
        run_op(2, 2'b01, 1'b0, 64'd2, '1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 10, "s4_us");
        run_op(1, 2'b11, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 10, "s2_w");
        run_op(2, 2'b00, 1'b1, 64'hAAAA_5555_FFFF_FFFF, 64'h0F0F_0F0F_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 6, "s4_w");
    endtask

    task automatic test_random(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0]   s;
            logic         w;
            logic [63:0]  a;
            logic [63:0]  b;
            logic [63:0]  ar;
            logic [63:0]  br;
            logic [127:0] ea;
            logic [127:0] eb;
            logic [127:0] p;
            s  = 2'($urandom());
            w  = 1'($urandom());
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            ar = w ? {{32{s[1] & a[31]}}, a[31:0]} : a;
            br = w ? {{32{s[0] & b[31]}}, b[31:0]} : b;
            ea = {{64{s[1] & ar[63]}}, ar};
            eb = {{64{s[0] & br[63]}}, br};
            p  = ea * eb;
            if (w) p = {{32{p[63]}}, p[63:32], {32{p[31]}}, p[31:0]};
            run_op(idx, s, w, a, b, p[127:64], p[63:0], -1, "random");
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        mulw         = 1'b0;
        mul_signed   = 2'b00;
        multiplicand = '0;
        multiplier   = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
        test_reset();
        test_signed_modes();
        test_mulw();
        test_hold_and_flush();
        test_flush_corners();
        test_reset_mid_run();
        test_steps();
        test_random(0, 150);
        test_random(1, 150);
        test_random(2, 150);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
